// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization leaf-side logic.
package fractal_sync_pkg;

  // Default response type. Its fields match the tx output response.
  typedef struct packed {
    logic       wake;
    logic [1:0] dst;
    logic       error;
  } fsync_rsp_def_t;

  localparam int unsigned FSYNC_DST_W = 2;

  // Per-port wake driver states
  typedef enum logic {
    FSYNC_WAKE_IDLE = 1'b0,
    FSYNC_WAKE_WAKE = 1'b1
  } fsync_wake_state_e;

endpackage

// File: rtl/fractal_sync_wake_port.sv
// One port of the wake driver: pop/classify FSM, sticky error flag and
// saturating sync counter.
module fractal_sync_wake_port
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_rsp_t = fsync_rsp_def_t,
  parameter int unsigned DST_W       = FSYNC_DST_W,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             empty_i,
  input  fsync_rsp_t       rsp_i,
  output logic             pop_o,
  output logic             wake_o,
  output logic [DST_W-1:0] wake_dst_o,
  input  logic             ack_i,
  output logic             error_o,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] sync_cnt_o
);

  fsync_wake_state_e state_q, state_d;
  logic [DST_W-1:0]  dst_d;
  logic              err_set, cnt_inc;

  // Pop whenever the head is visible and the port can take it: idle, or
  // acknowledged in the same cycle (back-to-back delivery).
  always_comb begin
    pop_o = !rst_i && !empty_i && (state_q == FSYNC_WAKE_IDLE || ack_i);
  end

  // Next state: completion first, then classification of a popped element
  always_comb begin
    state_d = state_q;
    dst_d   = wake_dst_o;
    err_set = 1'b0;
    cnt_inc = 1'b0;
    if (state_q == FSYNC_WAKE_WAKE && ack_i) begin
      cnt_inc = 1'b1;
      state_d = FSYNC_WAKE_IDLE;
    end
    if (pop_o) begin
      if (rsp_i.error) begin
        err_set = 1'b1;
        state_d = FSYNC_WAKE_IDLE;
      end else if (rsp_i.wake) begin
        dst_d   = rsp_i.dst;
        state_d = FSYNC_WAKE_WAKE;
      end else begin
        state_d = FSYNC_WAKE_IDLE;
      end
    end
  end

  // State, delivered destination, sticky error (set wins over clear),
  // saturating counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FSYNC_WAKE_IDLE;
      wake_dst_o <= '0;
      error_o    <= 1'b0;
      sync_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      wake_dst_o <= dst_d;
      if (err_set)        error_o <= 1'b1;
      else if (err_clr_i) error_o <= 1'b0;
      if (cnt_inc && sync_cnt_o != {CNT_W{1'b1}})
        sync_cnt_o <= sync_cnt_o + 1'b1;
    end
  end

  // wake_o comes straight from the state register, so ack_i never reaches it
  // combinationally.
  assign wake_o = (state_q == FSYNC_WAKE_WAKE);

endmodule

// File: rtl/fractal_sync_wake_drv.sv
// Leaf-side consumer of the fractal sync tx response FIFOs: one wake port
// per FIFO plus a global busy indication.
module fractal_sync_wake_drv
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_rsp_t = fsync_rsp_def_t,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DST_W       = FSYNC_DST_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic       [NUM_PORTS-1:0]          empty_i,
  input  fsync_rsp_t [NUM_PORTS-1:0]          rsp_i,
  output logic       [NUM_PORTS-1:0]          pop_o,
  output logic       [NUM_PORTS-1:0]          wake_o,
  output logic       [NUM_PORTS-1:0][DST_W-1:0] wake_dst_o,
  input  logic       [NUM_PORTS-1:0]          ack_i,
  output logic       [NUM_PORTS-1:0]          error_o,
  input  logic       [NUM_PORTS-1:0]          err_clr_i,
  output logic       [NUM_PORTS-1:0][CNT_W-1:0] sync_cnt_o,
  output logic                                busy_o
);

  if (NUM_PORTS < 1) begin : g_bad_ports
    $error("fractal_sync_wake_drv: NUM_PORTS must be > 0");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("fractal_sync_wake_drv: CNT_W must be > 0");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fractal_sync_wake_port #(
      .fsync_rsp_t (fsync_rsp_t),
      .DST_W       (DST_W),
      .CNT_W       (CNT_W)
    ) u_port (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .empty_i    (empty_i[p]),
      .rsp_i      (rsp_i[p]),
      .pop_o      (pop_o[p]),
      .wake_o     (wake_o[p]),
      .wake_dst_o (wake_dst_o[p]),
      .ack_i      (ack_i[p]),
      .error_o    (error_o[p]),
      .err_clr_i  (err_clr_i[p]),
      .sync_cnt_o (sync_cnt_o[p])
    );
  end

  // Busy while any port is delivering a wake or has a pending response
  always_comb begin
    busy_o = |(wake_o | ~empty_i);
  end

endmodule

// File: tb/tb_fractal_sync_wake_drv.sv
// Directed self-checking bench for fractal_sync_wake_drv (2 ports, 2-bit
// counters so saturation is reachable quickly).
module tb_fractal_sync_wake_drv;
  import fractal_sync_pkg::*;

  localparam int NP = 2;
  localparam int CW = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic           [NP-1:0]       empty;
  fsync_rsp_def_t [NP-1:0]       rsp;
  logic           [NP-1:0]       pop, wake, ack, err, err_clr;
  logic           [NP-1:0][1:0]  dst;
  logic           [NP-1:0][CW-1:0] cnt;
  logic                          busy;

  int n_cmp = 0;
  int n_bad = 0;

  fractal_sync_wake_drv #(
    .fsync_rsp_t (fsync_rsp_def_t),
    .NUM_PORTS   (NP),
    .CNT_W       (CW),
    .DST_W       (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .empty_i    (empty),
    .rsp_i      (rsp),
    .pop_o      (pop),
    .wake_o     (wake),
    .wake_dst_o (dst),
    .ack_i      (ack),
    .error_o    (err),
    .err_clr_i  (err_clr),
    .sync_cnt_o (cnt),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; registered outputs are sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic fsync_rsp_def_t mk(input logic w, input logic [1:0] d, input logic e);
    fsync_rsp_def_t r;
    r.wake = w; r.dst = d; r.error = e;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; empty = '1; ack = '0; err_clr = '0;
    #1 chk("pop_in_reset", 32'(pop), 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; empty = '1; ack = '0; err_clr = '0;
    rsp[0] = mk(0, 0, 0); rsp[1] = mk(0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_wake", 32'(wake), 0);
    chk("rst_dst", 32'(dst), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(cnt), 0);
    #1 chk("rst_busy", 32'(busy), 0);

    // Single wake
    empty[0] = 1'b0; rsp[0] = mk(1, 2'd1, 0);
    #1 chk("sw_pop", 32'(pop), 32'b01);
    chk("sw_busy", 32'(busy), 1);
    tick(); empty[0] = 1'b1;
    chk("sw_wake", 32'(wake), 32'b01);
    chk("sw_dst", 32'(dst[0]), 1);
    #1 chk("sw_nopop", 32'(pop), 0);
    tick(); tick(); tick();
    chk("sw_hold", 32'(wake), 32'b01);
    chk("sw_cnt0", 32'(cnt[0]), 0);
    ack[0] = 1'b1;
    #1 chk("sw_ack_nopop", 32'(pop), 0);
    tick(); ack[0] = 1'b0;
    chk("sw_done_wake", 32'(wake), 0);
    chk("sw_cnt1", 32'(cnt[0]), 1);
    // ack while idle is ignored
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("idle_ack_cnt", 32'(cnt[0]), 1);

    // Back-to-back with ack tied high
    do_reset();
    ack[0] = 1'b1;
    empty[0] = 1'b0; rsp[0] = mk(1, 2'd1, 0);
    #1 chk("b2b_pop1", 32'(pop[0]), 1);
    tick(); rsp[0] = mk(1, 2'd2, 0);
    chk("b2b_dst1", 32'(dst[0]), 1);
    chk("b2b_cnt_a", 32'(cnt[0]), 0);
    #1 chk("b2b_pop2", 32'(pop[0]), 1);
    tick(); rsp[0] = mk(1, 2'd3, 0);
    chk("b2b_dst2", 32'(dst[0]), 2);
    chk("b2b_cnt_b", 32'(cnt[0]), 1);
    #1 chk("b2b_pop3", 32'(pop[0]), 1);
    tick(); empty[0] = 1'b1;
    chk("b2b_dst3", 32'(dst[0]), 3);
    chk("b2b_wake3", 32'(wake[0]), 1);
    chk("b2b_cnt_c", 32'(cnt[0]), 2);
    tick(); ack[0] = 1'b0;
    chk("b2b_idle", 32'(wake[0]), 0);
    chk("b2b_cnt3", 32'(cnt[0]), 3);

    // Backpressure: stalled in WAKE with a non-empty FIFO
    empty[0] = 1'b0; rsp[0] = mk(1, 2'd2, 0);
    tick(); rsp[0] = mk(1, 2'd3, 0);
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_pop", 32'(pop[0]), 0);
      chk("bp_dst", 32'(dst[0]), 2);
      chk("bp_wake", 32'(wake[0]), 1);
      tick();
    end
    ack[0] = 1'b1;
    #1 chk("bp_release_pop", 32'(pop[0]), 1);
    tick(); empty[0] = 1'b1;
    chk("bp_next_dst", 32'(dst[0]), 3);
    chk("bp_cnt_sat", 32'(cnt[0]), 3);
    tick(); ack[0] = 1'b0;
    chk("bp_done", 32'(wake[0]), 0);

    // Error handling
    do_reset();
    empty[0] = 1'b0; rsp[0] = mk(1, 2'd3, 1);
    #1 chk("er_pop", 32'(pop[0]), 1);
    tick();
    chk("er_flag", 32'(err[0]), 1);
    chk("er_nowake", 32'(wake[0]), 0);
    err_clr[0] = 1'b1;
    tick(); empty[0] = 1'b1;
    chk("er_set_wins", 32'(err[0]), 1);
    tick(); err_clr[0] = 1'b0;
    chk("er_cleared", 32'(err[0]), 0);
    chk("er_dst", 32'(dst[0]), 0);
    // silent discard of wake=0
    empty[0] = 1'b0; rsp[0] = mk(0, 2'd2, 0);
    #1 chk("dis_pop", 32'(pop[0]), 1);
    tick(); empty[0] = 1'b1;
    chk("dis_wake", 32'(wake[0]), 0);
    chk("dis_err", 32'(err[0]), 0);

    // Saturation on port 0, unrelated traffic on port 1
    do_reset();
    ack[0] = 1'b1;
    empty = 2'b00; rsp[0] = mk(1, 2'd1, 0); rsp[1] = mk(0, 2'd0, 1);
    tick(); rsp[1] = mk(1, 2'd2, 0);
    tick(); empty[1] = 1'b1; ack[1] = 1'b0;
    tick(); tick(); tick(); empty[0] = 1'b1;
    tick(); ack[0] = 1'b0;
    chk("sat_cnt0", 32'(cnt[0]), 3);
    chk("sat_wake0", 32'(wake[0]), 0);
    chk("sat_err0", 32'(err[0]), 0);
    chk("ind_cnt1", 32'(cnt[1]), 0);
    chk("ind_wake1", 32'(wake[1]), 1);
    chk("ind_dst1", 32'(dst[1]), 2);
    chk("ind_err1", 32'(err[1]), 1);

    // Reset mid-WAKE (port 1 still waking from above, port 0 enters WAKE)
    empty[0] = 1'b0; rsp[0] = mk(1, 2'd1, 0);
    tick(); rsp[0] = mk(1, 2'd2, 0);
    chk("mr_pre_wake", 32'(wake), 32'b11);
    rst = 1'b1;
    #1 chk("mr_pop_forced", 32'(pop), 0);
    tick(); rst = 1'b0; empty = 2'b11;
    chk("mr_wake", 32'(wake), 0);
    chk("mr_dst", 32'(dst), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_cnt", 32'(cnt), 0);
    #1 chk("mr_busy_idle", 32'(busy), 0);
    empty[1] = 1'b0; rsp[1] = mk(1, 2'd3, 0);
    #1 chk("mr_busy_follow", 32'(busy), 1);
    chk("mr_fresh_pop", 32'(pop), 32'b10);
    tick(); empty[1] = 1'b1;
    chk("mr_fresh_wake", 32'(wake), 32'b10);
    chk("mr_fresh_dst", 32'(dst[1]), 3);
    ack[1] = 1'b1;
    tick(); ack[1] = 1'b0;
    chk("mr_fresh_cnt", 32'(cnt[1]), 1);
    chk("mr_fresh_done", 32'(wake), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
